// File: rtl/counter_base_b_multi.sv
// N-digit base-BASE up/down counter. Digits are binary fields chained by an
// explicit base-BASE carry/borrow. Parallel load sanitises digits, eu cascades, wrap is sticky.
module counter_base_b_multi #(
    parameter int  BASE   = 3,
    parameter int  DIGITS = 4,
    localparam int DW     = ($clog2(BASE) < 1) ? 1 : $clog2(BASE)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ei,
    input  logic                 dir,
    input  logic                 load,
    input  logic [DIGITS*DW-1:0] din,
    output logic [DIGITS*DW-1:0] q,
    output logic                 eu,
    output logic                 wrap,
    output logic                 ld_err
);
    localparam logic [DW-1:0] DIG_MAX  = DW'(BASE - 1);
    localparam logic [DW-1:0] DIG_ZERO = {DW{1'b0}};
    localparam logic [DW-1:0] DIG_ONE  = DW'(1);

    logic [DIGITS*DW-1:0] cnt_q;
    logic [DIGITS*DW-1:0] cnt_d;
    logic                 wrap_q;
    logic                 wrap_d;
    logic                 ld_err_q;
    logic                 ld_err_d;
    logic [DIGITS:0]      carry_s;
    logic [DIGITS*DW-1:0] load_val_s;
    logic                 load_bad_s;

    // Carry/borrow chain: digit k steps only when every lower digit sits at its boundary.
    always_comb begin
        carry_s    = {(DIGITS+1){1'b0}};
        carry_s[0] = ei;
        for (int k = 0; k < DIGITS; k++) begin
            if (dir) begin
                carry_s[k+1] = carry_s[k] & (cnt_q[k*DW +: DW] == DIG_ZERO);
            end else begin
                carry_s[k+1] = carry_s[k] & (cnt_q[k*DW +: DW] == DIG_MAX);
            end
        end
    end

    // Load sanitiser: out-of-range digits become 0 and flag an error.
    always_comb begin
        load_val_s = {(DIGITS*DW){1'b0}};
        load_bad_s = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (32'(din[k*DW +: DW]) < 32'(BASE)) begin
                load_val_s[k*DW +: DW] = din[k*DW +: DW];
            end else begin
                load_bad_s = 1'b1;
            end
        end
    end

    // Next-state: load has priority over counting, counting over hold.
    always_comb begin
        cnt_d    = cnt_q;
        wrap_d   = wrap_q;
        ld_err_d = 1'b0;
        if (load) begin
            cnt_d    = load_val_s;
            wrap_d   = 1'b0;
            ld_err_d = load_bad_s;
        end else if (ei) begin
            for (int k = 0; k < DIGITS; k++) begin
                if (!carry_s[k]) begin
                    cnt_d[k*DW +: DW] = cnt_q[k*DW +: DW];
                end else if (dir) begin
                    cnt_d[k*DW +: DW] = (cnt_q[k*DW +: DW] == DIG_ZERO) ? DIG_MAX
                                                                       : cnt_q[k*DW +: DW] - DIG_ONE;
                end else begin
                    cnt_d[k*DW +: DW] = (cnt_q[k*DW +: DW] == DIG_MAX) ? DIG_ZERO
                                                                      : cnt_q[k*DW +: DW] + DIG_ONE;
                end
            end
            // A carry leaving the top digit means the whole counter wrapped.
            if (carry_s[DIGITS]) begin
                wrap_d = 1'b1;
            end else begin
                wrap_d = wrap_q;
            end
        end else begin
            cnt_d  = cnt_q;
            wrap_d = wrap_q;
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q    <= {(DIGITS*DW){1'b0}};
            wrap_q   <= 1'b0;
            ld_err_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            wrap_q   <= wrap_d;
            ld_err_q <= ld_err_d;
        end
    end

    assign q      = cnt_q;
    assign wrap   = wrap_q;
    assign ld_err = ld_err_q;
    assign eu     = carry_s[DIGITS] & ~load;

endmodule
